// File: rtl/str_next_renderer.sv
// str_next_renderer: two-stage pixel pipeline for the "NEXT" caption.
// Stage 1 locates the raster position inside the glyph box and addresses the
// string ROM. Stage 2 picks the addressed pixel bit and registers the colour.
// A frame-counted blink FSM gates the caption.
module str_next_renderer #(
    parameter int          X0_P      = 400,
    parameter int          Y0_P      = 100,
    parameter int          GLYPHS_P  = 4,
    parameter int          GLYPH_W_P = 32,
    parameter int          GLYPH_H_P = 64,
    parameter int          BLINK_P   = 30,
    parameter logic [11:0] FG_P      = 12'hFFF,
    parameter logic [11:0] BG_P      = 12'h000
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [10:0] x_i,
    input  logic [9:0]  y_i,
    input  logic        de_i,
    input  logic        hsync_i,
    input  logic        vsync_i,
    input  logic        blink_en_i,
    output logic [7:0]  rom_addr_o,
    input  logic [31:0] rom_data_i,
    output logic [11:0] rgb_o,
    output logic        hit_o,
    output logic        de_o,
    output logic        hsync_o,
    output logic        vsync_o
);

    localparam logic [31:0] X_LO = 32'(X0_P);
    localparam logic [31:0] X_HI = 32'(X0_P + GLYPHS_P * GLYPH_W_P);
    localparam logic [31:0] Y_LO = 32'(Y0_P);
    localparam logic [31:0] Y_HI = 32'(Y0_P + GLYPH_H_P);
    localparam int          CW   = (BLINK_P > 1) ? $clog2(BLINK_P) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_P - 1);

    typedef enum logic {SHOW, HIDE} blink_t;

    blink_t          state;
    logic [CW-1:0]   frame_cnt;
    logic            vsync_q;
    logic            vs_rise;
    logic            show;

    logic [31:0]     xw;
    logic [31:0]     yw;
    logic [31:0]     dx;
    logic [31:0]     dy;
    logic            in_box;
    logic [7:0]      next_addr;
    logic [4:0]      next_col;

    logic            in_box_q;
    logic [4:0]      col_q;
    logic            de_q;
    logic            hs_q;
    logic            vs_q;
    logic [4:0]      px_idx;
    logic            pix_bit;

    // Box test and glyph/column decode; 32-bit arithmetic so nothing wraps.
    always_comb begin
        xw        = 32'(x_i);
        yw        = 32'(y_i);
        in_box    = de_i && (xw >= X_LO) && (xw < X_HI) && (yw >= Y_LO) && (yw < Y_HI);
        dx        = xw - X_LO;
        dy        = yw - Y_LO;
        next_addr = 8'((dx / 32'(GLYPH_W_P)) * 32'(GLYPH_H_P) + dy);
        next_col  = 5'(dx % 32'(GLYPH_W_P));
    end

    assign vs_rise = vsync_i & ~vsync_q;
    assign show    = (state == SHOW);
    assign px_idx  = 5'(GLYPH_W_P - 1) - col_q;
    assign pix_bit = rom_data_i[px_idx];

    // Stage 1: register box flag, column and syncs; ROM address holds outside the box.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rom_addr_o <= '0;
            in_box_q   <= 1'b0;
            col_q      <= '0;
            de_q       <= 1'b0;
            hs_q       <= 1'b0;
            vs_q       <= 1'b0;
        end else begin
            in_box_q <= in_box;
            de_q     <= de_i;
            hs_q     <= hsync_i;
            vs_q     <= vsync_i;
            if (in_box) begin
                rom_addr_o <= next_addr;
                col_q      <= next_col;
            end else begin
                col_q      <= '0;
            end
        end
    end

    // Blink FSM: counts vsync rising edges, toggles SHOW/HIDE every BLINK_P frames.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state     <= SHOW;
            frame_cnt <= '0;
            vsync_q   <= 1'b0;
        end else begin
            vsync_q <= vsync_i;
            if (!blink_en_i) begin
                state     <= SHOW;
                frame_cnt <= '0;
            end else if (vs_rise) begin
                if (frame_cnt == CNT_LAST) begin
                    frame_cnt <= '0;
                    state     <= (state == SHOW) ? HIDE : SHOW;
                end else begin
                    frame_cnt <= frame_cnt + CW'(1);
                end
            end
        end
    end

    // Stage 2: select the pixel bit (MSB = leftmost) and register colour and syncs.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rgb_o   <= BG_P;
            hit_o   <= 1'b0;
            de_o    <= 1'b0;
            hsync_o <= 1'b0;
            vsync_o <= 1'b0;
        end else begin
            hit_o   <= in_box_q & show;
            rgb_o   <= (in_box_q & show & pix_bit) ? FG_P : BG_P;
            de_o    <= de_q;
            hsync_o <= hs_q;
            vsync_o <= vs_q;
        end
    end

endmodule

// File: tb/tb_str_next_renderer.sv
// Bench for str_next_renderer: directed caption pixels plus randomized raster
// streams checked against a coordinate-level model of the caption.
module tb_str_next_renderer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] x;
    logic [9:0]  y;
    logic        de, hsync, vsync, blink_en;
    logic [7:0]  rom_addr;
    logic [31:0] rom_data;
    logic [11:0] rgb;
    logic        hit, de_o, hsync_o, vsync_o;

    logic [31:0] rom [256];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign rom_data = rom[rom_addr];

    str_next_renderer #(.BLINK_P(2)) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .x_i        (x),
        .y_i        (y),
        .de_i       (de),
        .hsync_i    (hsync),
        .vsync_i    (vsync),
        .blink_en_i (blink_en),
        .rom_addr_o (rom_addr),
        .rom_data_i (rom_data),
        .rgb_o      (rgb),
        .hit_o      (hit),
        .de_o       (de_o),
        .hsync_o    (hsync_o),
        .vsync_o    (vsync_o)
    );

    // Caption model: {hit, rgb} for a pixel given the show flag.
    function automatic logic [12:0] model_pix(input int px, input int py, input logic d, input logic sh);
        logic [31:0] w;
        int g, c;
        if (d && px >= 400 && px < 528 && py >= 100 && py < 164) begin
            g = (px - 400) / 32;
            c = (px - 400) % 32;
            w = rom[g * 64 + (py - 100)];
            return {sh, (sh && w[31 - c]) ? 12'hFFF : 12'h000};
        end
        return {1'b0, 12'h000};
    endfunction

    function automatic logic [7:0] model_addr(input int px, input int py);
        return 8'(((px - 400) / 32) * 64 + (py - 100));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_px(input int px, input int py, input logic d, input logic h, input logic v);
        x     = 11'(px);
        y     = 10'(py);
        de    = d;
        hsync = h;
        vsync = v;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 6; i++) begin
            set_px($urandom_range(1400, 0), $urandom_range(800, 0), 1'($urandom), 1'($urandom), 1'($urandom));
            blink_en = 1'($urandom);
            tick();
            total++;
            if (rgb !== 12'h000) begin bad++; $display("FAIL reset_rgb got=%h exp=000", rgb); end
            total++;
            if (hit !== 1'b0) begin bad++; $display("FAIL reset_hit got=%b exp=0", hit); end
            total++;
            if ({de_o, hsync_o, vsync_o} !== 3'b000) begin bad++; $display("FAIL reset_syncs got=%b exp=000", {de_o, hsync_o, vsync_o}); end
            total++;
            if (rom_addr !== 8'h00) begin bad++; $display("FAIL reset_addr got=%0d exp=0", rom_addr); end
        end
        set_px(0, 0, 1'b0, 1'b0, 1'b0);
        blink_en = 1'b0;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_pixel();
        set_px(401, 111, 1'b1, 1'b0, 1'b0);
        tick();
        total++;
        if (rom_addr !== 8'd11) begin bad++; $display("FAIL pix401_addr got=%0d exp=11", rom_addr); end
        tick();
        total++;
        if ({hit, rgb} !== {1'b1, 12'hFFF}) begin bad++; $display("FAIL pix401_rgb got=%b/%h exp=1/fff", hit, rgb); end
        set_px(400, 111, 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        total++;
        if ({hit, rgb} !== {1'b1, 12'h000}) begin bad++; $display("FAIL pix400_rgb got=%b/%h exp=1/000", hit, rgb); end
    endtask

    task automatic test_glyph1();
        set_px(445, 125, 1'b1, 1'b0, 1'b0);
        tick();
        total++;
        if (rom_addr !== 8'd89) begin bad++; $display("FAIL g1_addr got=%0d exp=89", rom_addr); end
        tick();
        total++;
        if ({hit, rgb} !== {1'b1, 12'hFFF}) begin bad++; $display("FAIL g1_445 got=%b/%h exp=1/fff", hit, rgb); end
        set_px(444, 125, 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        total++;
        if ({hit, rgb} !== {1'b1, 12'h000}) begin bad++; $display("FAIL g1_444 got=%b/%h exp=1/000", hit, rgb); end
    endtask

    task automatic test_edges();
        int ex[4] = '{399, 528, 401, 401};
        int ey[4] = '{111, 111, 99, 164};
        logic [12:0] e;
        for (int i = 0; i < 4; i++) begin
            set_px(ex[i], ey[i], 1'b1, 1'b0, 1'b0);
            tick();
            tick();
            total++;
            if ({hit, rgb} !== {1'b0, 12'h000})
                begin bad++; $display("FAIL edge_%0d_%0d got=%b/%h exp=0/000", ex[i], ey[i], hit, rgb); end
        end
        set_px(527, 163, 1'b1, 1'b0, 1'b0);
        e = model_pix(527, 163, 1'b1, 1'b1);
        tick();
        total++;
        if (rom_addr !== 8'd255) begin bad++; $display("FAIL corner_addr got=%0d exp=255", rom_addr); end
        tick();
        total++;
        if ({hit, rgb} !== e) begin bad++; $display("FAIL corner_rgb got=%b/%h exp=%b/%h", hit, rgb, e[12], e[11:0]); end
    endtask

    task automatic test_random_stream();
        localparam int N = 400;
        logic [12:0] exp_pix [N];
        logic [2:0]  exp_sync [N];
        logic [7:0]  exp_addr [N];
        logic        exp_in [N];
        int px, py;
        logic d, h, v;
        blink_en = 1'b0;
        for (int i = 0; i < N; i++) begin
            px = $urandom_range(540, 380);
            py = $urandom_range(170, 90);
            d  = ($urandom_range(3, 0) != 0);
            h  = 1'($urandom);
            v  = 1'($urandom);
            set_px(px, py, d, h, v);
            exp_pix[i]  = model_pix(px, py, d, 1'b1);
            exp_sync[i] = {d, h, v};
            exp_in[i]   = exp_pix[i][12];
            exp_addr[i] = model_addr(px, py);
            tick();
            if (exp_in[i]) begin
                total++;
                if (rom_addr !== exp_addr[i]) begin bad++; $display("FAIL rnd_addr[%0d] got=%0d exp=%0d", i, rom_addr, exp_addr[i]); end
            end
            if (i >= 1) begin
                total++;
                if ({hit, rgb} !== exp_pix[i-1])
                    begin bad++; $display("FAIL rnd_pix[%0d] got=%b/%h exp=%b/%h", i-1, hit, rgb, exp_pix[i-1][12], exp_pix[i-1][11:0]); end
                total++;
                if ({de_o, hsync_o, vsync_o} !== exp_sync[i-1])
                    begin bad++; $display("FAIL rnd_sync[%0d] got=%b exp=%b", i-1, {de_o, hsync_o, vsync_o}, exp_sync[i-1]); end
            end
        end
    endtask

    task automatic test_blink();
        logic sh;
        set_px(401, 111, 1'b1, 1'b0, 1'b0);
        blink_en = 1'b0;
        repeat (3) tick();
        blink_en = 1'b1;
        repeat (2) tick();
        for (int f = 0; f < 5; f++) begin
            // frames 0..4 with BLINK_P=2: shown for two frames, hidden for two
            sh = (((f / 2) % 2) == 0);
            total++;
            if ({hit, rgb} !== {sh, sh ? 12'hFFF : 12'h000})
                begin bad++; $display("FAIL blink_frame%0d got=%b/%h exp=%b", f, hit, rgb, sh); end
            if (f < 4) begin
                vsync = 1'b1; tick();
                vsync = 1'b0; repeat (3) tick();
            end
        end
        repeat (2) begin
            vsync = 1'b1; tick();
            vsync = 1'b0; repeat (3) tick();
        end
        total++;
        if (hit !== 1'b0) begin bad++; $display("FAIL blink_hidden got=%b exp=0", hit); end
        blink_en = 1'b0;
        tick();
        total++;
        if (hit !== 1'b0) begin bad++; $display("FAIL blink_inflight got=%b exp=0", hit); end
        tick();
        total++;
        if ({hit, rgb} !== {1'b1, 12'hFFF}) begin bad++; $display("FAIL blink_drop got=%b/%h exp=1/fff", hit, rgb); end
    endtask

    task automatic test_mid_reset();
        blink_en = 1'b0;
        set_px(401, 111, 1'b1, 1'b1, 1'b1);
        repeat (3) tick();
        total++;
        if ({hit, rgb, de_o, hsync_o, vsync_o} !== {1'b1, 12'hFFF, 3'b111})
            begin bad++; $display("FAIL midrst_pre got=%b/%h/%b exp=1/fff/111", hit, rgb, {de_o, hsync_o, vsync_o}); end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({hit, rgb, de_o, hsync_o, vsync_o, rom_addr} !== {1'b0, 12'h000, 3'b000, 8'h00})
            begin bad++; $display("FAIL midrst_clear got=%b/%h/%b/%0d exp=0/000/000/0", hit, rgb, {de_o, hsync_o, vsync_o}, rom_addr); end
        tick();
        rst_n = 1'b1;
        tick();
        total++;
        if (hit !== 1'b0) begin bad++; $display("FAIL midrst_rel1 got=%b exp=0", hit); end
        tick();
        total++;
        if ({hit, rgb, de_o, hsync_o, vsync_o} !== {1'b1, 12'hFFF, 3'b111})
            begin bad++; $display("FAIL midrst_rel2 got=%b/%h/%b exp=1/fff/111", hit, rgb, {de_o, hsync_o, vsync_o}); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = $urandom;
        rom[11] = 32'h7FC003FF;
        rom[89] = 32'h0007FC00;
        rst_n = 1'b1;
        blink_en = 1'b0;
        set_px(0, 0, 1'b0, 1'b0, 1'b0);
        #1 rst_n = 1'b0;
        test_reset();
        test_pixel();
        test_glyph1();
        test_edges();
        test_random_stream();
        test_blink();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
